// File: rtl/xm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xm_ctrl_pkg
// Shared types and constants for the X-Makina sequencing controller:
//   state_e   controller states (also exported on the debug state port)
//   cls_e     instruction class encodings found in ir[15:13]
//   field bit positions inside the instruction word
//   register write mode encodings
// ---------------------------------------------------------------------------
package xm_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_F_ADDR = 4'd1,
    ST_F_REQ  = 4'd2,
    ST_DECODE = 4'd3,
    ST_EXEC   = 4'd4,
    ST_BRANCH = 4'd5,
    ST_M_ADDR = 4'd6,
    ST_M_REQ  = 4'd7,
    ST_WB     = 4'd8,
    ST_FAULT  = 4'd9
  } state_e;

  // Class codes 101..111 are reserved and have no enum member.
  typedef enum logic [2:0] {
    CLS_BR  = 3'b000,
    CLS_BC  = 3'b001,
    CLS_ALU = 3'b010,
    CLS_LD  = 3'b011,
    CLS_ST  = 3'b100
  } cls_e;

  localparam int CLS_HI   = 15;
  localparam int CLS_LO   = 13;
  localparam int BYTE_BIT = 6;
  localparam int SRC_HI   = 5;
  localparam int SRC_LO   = 3;
  localparam int DST_HI   = 2;
  localparam int DST_LO   = 0;

  localparam logic [1:0] WRMODE_WORD = 2'b00;
  localparam logic [1:0] WRMODE_LOW  = 2'b01;

endpackage

// File: rtl/xm_instr_decode.sv
// ---------------------------------------------------------------------------
// xm_instr_decode
// Purely combinational split of the instruction register into the fields the
// controller needs.
//   ir        in   WORD  current IR contents
//   cls       out  3     instruction class (ir[15:13])
//   reserved  out  1     class code is not one of BR/BC/ALU/LD/ST
//   src       out  3     source register (ir[5:3])
//   dst       out  3     destination register (ir[2:0])
//   byte_op   out  1     byte flag (ir[6])
// ---------------------------------------------------------------------------
module xm_instr_decode
  import xm_ctrl_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic [WORD-1:0] ir,
  output logic [2:0]      cls,
  output logic            reserved,
  output logic [2:0]      src,
  output logic [2:0]      dst,
  output logic            byte_op
);

  assign cls      = ir[CLS_HI:CLS_LO];
  assign reserved = (cls > CLS_ST);
  assign src      = ir[SRC_HI:SRC_LO];
  assign dst      = ir[DST_HI:DST_LO];
  assign byte_op  = ir[BYTE_BIT];

  // Operand/offset bits are consumed by the datapath, not the controller.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[CLS_LO-1:BYTE_BIT+1];

endmodule

// File: rtl/xm_controller.sv
// ---------------------------------------------------------------------------
// xm_controller
// Multi-cycle sequencer for the X-Makina datapath: fetch, decode, execute /
// branch / memory access, writeback. Memory accesses use a request/ready
// handshake with a bounded wait; bad address, timeout or a reserved class
// parks the controller in a sticky FAULT state until reset.
//
// Handshake: memReq_o is held high for every cycle spent in F_REQ/M_REQ. The
// access completes in the cycle where memRdy_i=1 and badMem_i=0; completion
// strobes are combinationally gated by that condition. badMem_i beats
// memRdy_i. If the wait counter has reached WAIT_MAX and memRdy_i is still
// low, the controller faults (16th REQ cycle for WAIT_MAX=15).
//
// Ports:
//   clk_i, arst_i (synchronous, active-high)
//   ir_i, condTrue_i, badMem_i, memRdy_i       datapath / memory status
//   memReq_o, memRnw_o                         memory request, 1=read
//   pcWr_o regWr_o memEn_o memWr_o irWr_o      datapath strobes
//   byteOp_o pcSel_o regWrMode_o               operation qualifiers
//   regWrAdr_o regAdrA_o regAdrB_o             register addresses
//   done_o (retire pulse), fault_o (in FAULT)
//   state_o                                    current state, for debug
// ---------------------------------------------------------------------------
module xm_controller
  import xm_ctrl_pkg::*;
#(
  parameter int WORD     = 16,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [WORD-1:0] ir_i,
  input  logic            condTrue_i,
  input  logic            badMem_i,
  input  logic            memRdy_i,
  output logic            memReq_o,
  output logic            memRnw_o,
  output logic            pcWr_o,
  output logic            regWr_o,
  output logic            memEn_o,
  output logic            memWr_o,
  output logic            irWr_o,
  output logic            byteOp_o,
  output logic            pcSel_o,
  output logic [1:0]      regWrMode_o,
  output logic [2:0]      regWrAdr_o,
  output logic [2:0]      regAdrA_o,
  output logic [2:0]      regAdrB_o,
  output logic            done_o,
  output logic            fault_o,
  output state_e          state_o
);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic [2:0] cls;
  logic       cls_rsvd;
  logic [2:0] src;
  logic [2:0] dst;
  logic       byte_flag;

  xm_instr_decode #(.WORD(WORD)) u_dec (
    .ir       (ir_i),
    .cls      (cls),
    .reserved (cls_rsvd),
    .src      (src),
    .dst      (dst),
    .byte_op  (byte_flag)
  );

  logic is_ld;
  logic mem_done;
  logic timeout;

  assign is_ld    = (cls == CLS_LD);
  assign mem_done = memRdy_i & ~badMem_i;
  assign timeout  = (wait_cnt == WAIT_W'(WAIT_MAX));

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state    <= ST_RESET;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RESET:  state <= ST_F_ADDR;
        ST_F_ADDR: begin
          state    <= ST_F_REQ;
          wait_cnt <= '0;
        end
        ST_F_REQ: begin
          if (badMem_i)      state <= ST_FAULT;
          else if (memRdy_i) state <= ST_DECODE;
          else if (timeout)  state <= ST_FAULT;
          else               wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_DECODE: begin
          if (cls_rsvd)                          state <= ST_FAULT;
          else if (cls == CLS_BR || cls == CLS_BC) state <= ST_BRANCH;
          else if (cls == CLS_ALU)               state <= ST_EXEC;
          else                                   state <= ST_M_ADDR;
        end
        ST_EXEC, ST_BRANCH, ST_WB: state <= ST_F_ADDR;
        ST_M_ADDR: begin
          state    <= ST_M_REQ;
          wait_cnt <= '0;
        end
        ST_M_REQ: begin
          if (badMem_i)      state <= ST_FAULT;
          else if (memRdy_i) state <= is_ld ? ST_WB : ST_F_ADDR;
          else if (timeout)  state <= ST_FAULT;
          else               wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_FAULT;
      endcase
    end
  end

  // -------------------------------------------------------- output decode
  always_comb begin
    memReq_o    = 1'b0;
    memRnw_o    = 1'b1;
    pcWr_o      = 1'b0;
    regWr_o     = 1'b0;
    memEn_o     = 1'b0;
    memWr_o     = 1'b0;
    irWr_o      = 1'b0;
    byteOp_o    = 1'b0;
    pcSel_o     = 1'b0;
    regWrMode_o = WRMODE_WORD;
    regWrAdr_o  = 3'd0;
    regAdrA_o   = 3'd0;
    regAdrB_o   = 3'd0;
    done_o      = 1'b0;
    fault_o     = 1'b0;

    // Field-derived outputs follow IR in every live state; they are only
    // meaningful from DECODE onward.
    if (state != ST_RESET && state != ST_FAULT) begin
      regAdrA_o   = src;
      regAdrB_o   = dst;
      regWrAdr_o  = dst;
      byteOp_o    = byte_flag;
      regWrMode_o = byte_flag ? WRMODE_LOW : WRMODE_WORD;
    end

    case (state)
      ST_F_ADDR: memEn_o = 1'b1;
      ST_F_REQ: begin
        memReq_o = 1'b1;
        if (mem_done) begin
          memWr_o = 1'b1;
          irWr_o  = 1'b1;
          pcWr_o  = 1'b1;
        end
      end
      ST_EXEC: begin
        regWr_o = 1'b1;
        done_o  = 1'b1;
      end
      ST_BRANCH: begin
        done_o = 1'b1;
        if (cls == CLS_BR || condTrue_i) begin
          pcSel_o = 1'b1;
          pcWr_o  = 1'b1;
        end
      end
      ST_M_ADDR: memEn_o = 1'b1;
      ST_M_REQ: begin
        memReq_o = 1'b1;
        memRnw_o = is_ld;
        if (mem_done) begin
          if (is_ld) memWr_o = 1'b1;
          else       done_o  = 1'b1;
        end
      end
      ST_WB: begin
        regWr_o = 1'b1;
        done_o  = 1'b1;
      end
      ST_FAULT: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_xm_controller.sv
// ---------------------------------------------------------------------------
// tb_xm_controller
// Self-checking bench. A per-instruction timeline model derived from the
// cycle-by-cycle behaviour of each instruction class builds the expected
// output vector of every cycle; each vector is compared against the DUT
// under a care mask.
// ---------------------------------------------------------------------------
module tb_xm_controller;
  import xm_ctrl_pkg::*;

  localparam int WAIT_MAX = 15;

  // Output vector bit layout
  localparam logic [21:0] V_REQ   = 22'd1 << 21;
  localparam logic [21:0] V_RNW   = 22'd1 << 20;
  localparam logic [21:0] V_PCWR  = 22'd1 << 19;
  localparam logic [21:0] V_REGWR = 22'd1 << 18;
  localparam logic [21:0] V_MEMEN = 22'd1 << 17;
  localparam logic [21:0] V_MEMWR = 22'd1 << 16;
  localparam logic [21:0] V_IRWR  = 22'd1 << 15;
  localparam logic [21:0] V_PCSEL = 22'd1 << 13;
  localparam logic [21:0] V_DONE  = 22'd1 << 1;
  localparam logic [21:0] V_FAULT = 22'd1 << 0;
  localparam logic [21:0] M_CTRL  = V_REQ | V_PCWR | V_REGWR | V_MEMEN | V_MEMWR |
                                    V_IRWR | V_PCSEL | V_DONE | V_FAULT;
  localparam logic [21:0] M_RNW   = V_RNW;
  localparam logic [21:0] M_FLD   = 22'h007FFC;
  localparam logic [21:0] M_ALL   = 22'h3FFFFF;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_i     = 1'b1;
  logic [15:0] ir_i       = '0;
  logic        condTrue_i = 1'b0;
  logic        badMem_i   = 1'b0;
  logic        memRdy_i   = 1'b0;

  logic       memReq_o, memRnw_o, pcWr_o, regWr_o, memEn_o, memWr_o, irWr_o;
  logic       byteOp_o, pcSel_o, done_o, fault_o;
  logic [1:0] regWrMode_o;
  logic [2:0] regWrAdr_o, regAdrA_o, regAdrB_o;
  state_e     dut_state;

  xm_controller #(.WORD(16), .WAIT_MAX(WAIT_MAX), .WAIT_W(4)) dut (
    .clk_i       (clk),
    .arst_i      (arst_i),
    .ir_i        (ir_i),
    .condTrue_i  (condTrue_i),
    .badMem_i    (badMem_i),
    .memRdy_i    (memRdy_i),
    .memReq_o    (memReq_o),
    .memRnw_o    (memRnw_o),
    .pcWr_o      (pcWr_o),
    .regWr_o     (regWr_o),
    .memEn_o     (memEn_o),
    .memWr_o     (memWr_o),
    .irWr_o      (irWr_o),
    .byteOp_o    (byteOp_o),
    .pcSel_o     (pcSel_o),
    .regWrMode_o (regWrMode_o),
    .regWrAdr_o  (regWrAdr_o),
    .regAdrA_o   (regAdrA_o),
    .regAdrB_o   (regAdrB_o),
    .done_o      (done_o),
    .fault_o     (fault_o),
    .state_o     (dut_state)
  );

  logic [21:0] dut_vec;
  assign dut_vec = {memReq_o, memRnw_o, pcWr_o, regWr_o, memEn_o, memWr_o, irWr_o,
                    byteOp_o, pcSel_o, regWrMode_o, regWrAdr_o, regAdrA_o, regAdrB_o,
                    done_o, fault_o};

  // ------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] cur_ir   = '0;
  logic        cur_cond = 1'b0;

  task automatic chk(input string tag, input logic [21:0] act, input logic [21:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ir=%h got=%h want=%h @%0t", tag, cur_ir, act, exp, $time);
    end
  endtask

  // Expected register-field outputs for an instruction word.
  function automatic logic [21:0] fields(input logic [15:0] ir);
    logic [21:0] v;
    v        = '0;
    v[14]    = ir[6];
    v[12:11] = ir[6] ? 2'b01 : 2'b00;
    v[10:8]  = ir[2:0];
    v[7:5]   = ir[5:3];
    v[4:2]   = ir[2:0];
    return v;
  endfunction

  // ------------------------------------------------------ driver tasks
  // One clock cycle: drive inputs at negedge, sample 1 time unit later.
  task automatic step(input logic rdy, input logic bad, input logic [21:0] e,
                      input logic [21:0] m, input string tag);
    @(negedge clk);
    ir_i       = cur_ir;
    condTrue_i = cur_cond;
    memRdy_i   = rdy;
    badMem_i   = bad;
    #1;
    chk(tag, dut_vec & m, e & m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_i   = 1'b1;
    memRdy_i = 1'b0;
    badMem_i = 1'b0;
    @(negedge clk);
    arst_i = 1'b0;
    #1;
    chk("reset_state", dut_vec, V_RNW);
  endtask

  task automatic expect_fault();
    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), V_FAULT, M_CTRL, "fault");
    do_reset();
  endtask

  // Memory request phase: ready on wait cycle wait_n, bad address on cycle
  // bad_k (with ready also high, to show bad wins), or timeout after
  // WAIT_MAX+1 cycles without ready.
  task automatic req_phase(input int wait_n, input int bad_k, input logic [21:0] base,
                           input logic [21:0] rdy_vec, input logic [21:0] m,
                           input string tag, output logic faulted);
    faulted = 1'b0;
    for (int k = 0; k <= WAIT_MAX; k++) begin
      if (k == bad_k) begin
        step(1'b1, 1'b1, base, m, {tag, "_bad"});
        faulted = 1'b1;
        return;
      end
      if (k == wait_n) begin
        step(1'b1, 1'b0, rdy_vec, m, {tag, "_rdy"});
        return;
      end
      step(1'b0, 1'b0, base, m, {tag, "_wait"});
      if (k == WAIT_MAX) begin
        faulted = 1'b1;
        return;
      end
    end
  endtask

  // Reference model: full timeline of one instruction starting at F_ADDR.
  task automatic do_instr(input logic [15:0] ir, input logic cond, input int fwait,
                          input int mwait, input int fbad, input int mbad);
    logic [2:0]  cls;
    logic [21:0] f;
    logic [21:0] base;
    logic        flt;
    logic        ld;
    cls      = ir[15:13];
    f        = fields(ir);
    cur_ir   = ir;
    cur_cond = cond;
    step(1'b0, 1'b0, V_MEMEN, M_CTRL, "f_addr");
    req_phase(fwait, fbad, V_REQ | V_RNW, V_REQ | V_RNW | V_MEMWR | V_IRWR | V_PCWR,
              M_CTRL | M_RNW, "f_req", flt);
    if (flt) begin
      expect_fault();
      return;
    end
    step(1'b0, 1'b0, f, M_CTRL | M_FLD, "decode");
    case (cls)
      3'd0, 3'd1:
        step(1'b0, 1'b0, f | V_DONE | ((cls == 3'd0 || cond) ? (V_PCSEL | V_PCWR) : 22'd0),
             M_CTRL | M_FLD, "branch");
      3'd2:
        step(1'b0, 1'b0, f | V_REGWR | V_DONE, M_CTRL | M_FLD, "exec");
      3'd3, 3'd4: begin
        ld = (cls == 3'd3);
        step(1'b0, 1'b0, f | V_MEMEN, M_CTRL | M_FLD, "m_addr");
        base = f | V_REQ | (ld ? V_RNW : 22'd0);
        req_phase(mwait, mbad, base, ld ? (base | V_MEMWR) : (base | V_DONE),
                  M_CTRL | M_RNW | M_FLD, "m_req", flt);
        if (flt) expect_fault();
        else if (ld) step(1'b0, 1'b0, f | V_REGWR | V_DONE, M_CTRL | M_FLD, "wb");
      end
      default: expect_fault();
    endcase
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    do_reset();

    // Directed cases
    do_instr(16'h4013, 1'b0, 0, 0, -1, -1);    // ALU word
    do_instr(16'h4053, 1'b0, 0, 0, -1, -1);    // ALU byte
    do_instr(16'h600C, 1'b0, 0, 3, -1, -1);    // LD, 3 wait cycles
    do_instr(16'h8011, 1'b0, 0, 0, -1, -1);    // ST
    do_instr(16'h2000, 1'b0, 0, 0, -1, -1);    // BC not taken
    do_instr(16'h2000, 1'b1, 0, 0, -1, -1);    // BC taken
    do_instr(16'h0000, 1'b0, 0, 0, -1, -1);    // BR always taken
    do_instr(16'h4013, 1'b0, 99, 0, -1, -1);   // fetch timeout
    do_instr(16'h4013, 1'b0, WAIT_MAX, 0, -1, -1); // ready on last allowed cycle
    do_instr(16'h8011, 1'b0, 0, WAIT_MAX, -1, -1);
    do_instr(16'hE000, 1'b0, 0, 0, -1, -1);    // reserved class
    do_instr(16'h600C, 1'b0, 0, 0, -1, 1);     // bad address in M_REQ
    do_instr(16'h4013, 1'b0, 0, 0, 2, -1);     // bad address in F_REQ

    // Reset in the middle of an LD: no regWr, restart from F_ADDR
    cur_ir = 16'h600C;
    step(1'b0, 1'b0, V_MEMEN, M_CTRL, "abort_f_addr");
    step(1'b1, 1'b0, V_REQ | V_RNW | V_MEMWR | V_IRWR | V_PCWR, M_CTRL | M_RNW, "abort_f_req");
    step(1'b0, 1'b0, fields(16'h600C), M_CTRL | M_FLD, "abort_decode");
    step(1'b0, 1'b0, fields(16'h600C) | V_MEMEN, M_CTRL | M_FLD, "abort_m_addr");
    do_reset();
    do_instr(16'h4053, 1'b0, 1, 0, -1, -1);

    // Randomized instructions
    for (int n = 0; n < 200; n++) begin
      int r, fw, mw, fb, mb;
      logic [2:0]  cls;
      logic [15:0] ir;
      r   = $urandom_range(0, 19);
      cls = (r < 18) ? 3'(r % 5) : 3'(5 + (r % 3));
      ir  = {cls, 13'($urandom)};
      fw  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      mw  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      fb  = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
      mb  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2) : -1;
      do_instr(ir, 1'($urandom_range(0, 1)), fw, mw, fb, mb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xm_controller.md
Name: xm_controller

Overview:
- Multi-cycle sequencing FSM for the X-Makina datapath.
- Fetches each instruction into IR, decodes its class, then drives the datapath strobes, register addresses and write modes through execute, memory and writeback.
- Runs the memory request/ready handshake with a bounded wait, and stops in a sticky FAULT state on bad memory, timeout or a reserved opcode.

Parameters:
- WORD, 16: datapath word width; the instruction is WORD bits.
- WAIT_MAX, 15: maximum cycles waiting for memRdy_i before FAULT.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- arst_i  in  1  reset, synchronous, active-high.
- ir_i  in  WORD  current IR contents from the datapath.
- condTrue_i  in  1  branch condition evaluated from the PSW.
- badMem_i  in  1  address decoder flags an illegal MAR address.
- memRdy_i  in  1  memory completes the current access this cycle.
- memReq_o  out  1  memory access request.
- memRnw_o  out  1  1 = read, 0 = write.
- pcWr_o, regWr_o, memEn_o, memWr_o, irWr_o  out  1 each  datapath strobes.
- byteOp_o, pcSel_o  out  1 each  byte operation; 1 = PC takes branch offset.
- regWrMode_o  out  2  00 = word, 01 = low byte.
- regWrAdr_o, regAdrA_o, regAdrB_o  out  3 each  register addresses.
- done_o  out  1  one-cycle pulse when an instruction retires.
- fault_o  out  1  high while in FAULT.

Behaviour:
- States: RESET, F_ADDR, F_REQ, DECODE, EXEC, BRANCH, M_ADDR, M_REQ, WB, FAULT.
- Output timing: outputs are Moore decodes of the registered state. Exception: in F_REQ and M_REQ the completion strobes are also gated by memRdy_i.
- Reset: arst_i high forces state RESET and clears the wait counter. In RESET every output is 0 except memRnw_o = 1. RESET → F_ADDR on the next cycle. Reset mid-instruction aborts it with no strobe issued.
- Decode fields:
  - class = ir_i[15:13]: 000 BR, 001 BC, 010 ALU, 011 LD, 100 ST, others reserved.
  - src = ir_i[5:3] drives regAdrA_o.
  - dst = ir_i[2:0] drives regAdrB_o and regWrAdr_o.
  - ir_i[6] = byte flag: byteOp_o = 1 and regWrMode_o = 01; otherwise 00.
- F_ADDR: pcSel_o = 0, memEn_o = 1 (MAR ← PC). Next state F_REQ.
- F_REQ: memReq_o = 1, memRnw_o = 1.
  - badMem_i = 1 → FAULT. badMem_i has priority over memRdy_i.
  - memRdy_i = 1 → memWr_o = irWr_o = pcWr_o = 1 that cycle (IR ← mem, PC ← PC+2), then DECODE.
- DECODE: register addresses are valid. Next state by class: BR/BC → BRANCH, ALU → EXEC, LD/ST → M_ADDR, reserved → FAULT.
- EXEC: regWr_o = 1, then F_ADDR with done_o = 1.
- BRANCH:
  - BR, or BC with condTrue_i = 1: pcSel_o = 1, pcWr_o = 1.
  - BC with condTrue_i = 0: no PC write.
  - Either case: F_ADDR with done_o = 1.
- M_ADDR: memEn_o = 1 (MAR ← regA, OMDR ← regB). Next state M_REQ.
- M_REQ: memReq_o = 1, memRnw_o = 1 for LD, 0 for ST. badMem_i → FAULT. On memRdy_i:
  - LD: memWr_o = 1, irWr_o = 0 (IMDR ← mem), then WB.
  - ST: F_ADDR with done_o = 1.
- WB: regWr_o = 1, then F_ADDR with done_o = 1.
- Wait counter:
  - Cleared on entry to F_REQ/M_REQ; increments each REQ cycle with memRdy_i = 0.
  - If the counter equals WAIT_MAX and memRdy_i = 0 → FAULT.
  - memRdy_i = 1 in that same cycle wins (normal completion).
- FAULT: sticky. fault_o = 1, all strobes and memReq_o = 0. Exit only via arst_i.
- Latency with zero-wait memory (F_ADDR to next F_ADDR): ALU/BR/BC 4 cycles, ST 5, LD 6.

Decomposition:
- Package xm_ctrl_pkg:
  - state enum.
  - class enum (CLS_BR … CLS_ST).
  - field bit positions.
  - regWrMode encodings.
- Sub-module xm_instr_decode: combinational IR → class/src/dst/byte.
- FSM, wait counter and output decode remain in xm_controller.

Test Plan:
- Reset then ALU: ir_i = 0x4013, memRdy_i tied 1 → pcWr/irWr pulse in F_REQ; regAdrA = 2, regWrAdr = 3, regWr = 1, regWrMode = 00 in EXEC; done_o on cycle 4; repeat with 0x4053 → regWrMode = 01, byteOp = 1.
- LD 0x600C with memRdy_i delayed 3 cycles in M_REQ → memEn in M_ADDR, memRnw = 1, memWr = 1 with irWr = 0 on the ready cycle; WB regWrAdr = 4; total 9 cycles.
- ST 0x8011 → memRnw = 0 in M_REQ; no regWr; done_o after 5 cycles.
- BC 0x2000 with condTrue_i = 0 → no pcWr in BRANCH; with condTrue_i = 1 → pcSel = 1, pcWr = 1.
- memRdy_i held 0 in F_REQ → FAULT after WAIT_MAX+1 cycles; ready exactly on cycle WAIT_MAX+1 → completes normally. Reserved 0xE000 → FAULT from DECODE.
- badMem_i during M_REQ → FAULT, all strobes 0; arst_i pulse mid-LD → RESET then F_ADDR, no spurious regWr.
